coproc_frame_seq: RTL and testbench
===================================

Name: coproc_frame_seq

Overview:
- Frame-level sequencer for the image coprocessor's 3x3 filter pass.
- Accepts a command from the CPU-side register interface. Pulses the start of the DMA address generator. Primes the row-buffer banks with the first two image rows.
- Streams the remaining rows through the filter datapath and schedules one write-back handshake per output row.
- Signals completion with a done pulse and a sticky interrupt.

Parameters:
- IMG_W, 256, pixels per row; must be a power of two, at least 4.
- IMG_H, 256, rows per frame; at least 3. Output rows = IMG_H-2 (valid convolution, no padding).
- CW, $clog2(IMG_W), column counter width.
- RW, $clog2(IMG_H), row counter width.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  CPU command request
- cmd_ready  out  1  high only in IDLE with abort low
- cmd_op  in  2  filter select, latched on accept
- abort  in  1  cancel current frame
- dma_start  out  1  one-cycle start pulse to DMA address generator
- pix_valid  in  1  pixel available from image buffer read path
- pix_ready  out  1  sequencer accepts pixel (PRIME, RUN)
- dp_en  out  1  datapath enable, = accepted pixel in RUN
- dp_op  out  2  latched cmd_op
- col_idx  out  CW  column of the next pixel to accept
- row_idx  out  RW  output row currently being produced
- wb_req  out  1  row write-back request
- wb_ack  in  1  write-back complete
- busy  out  1  state != IDLE
- done  out  1  one-cycle frame-complete pulse
- irq  out  1  sticky completion interrupt
- irq_clr  in  1  clears irq

Behaviour:
- Reset values: state IDLE; dma_start, pix_ready, dp_en, wb_req, busy, done, irq = 0; cmd_ready = 1; col_idx, row_idx, dp_op = 0.
- Accepted pixel: acc = pix_valid & pix_ready.
- States:
  - IDLE, START, PRIME, RUN, ROW_WB, DONE.
- IDLE:
  - cmd_valid & cmd_ready -> latch dp_op, clear counters, go to START.
- START:
  - dma_start = 1 for exactly this cycle; go to PRIME.
- PRIME:
  - pix_ready = 1; dp_en = 0.
  - Each acc increments col_idx, wrapping IMG_W-1 -> 0.
  - A 1-bit prime-row flag toggles on wrap.
  - The second wrap goes to RUN with col_idx = 0 and row_idx = 0.
  - Exactly 2*IMG_W accepts spent here.
- RUN:
  - pix_ready = 1; dp_en = acc.
  - Each acc increments col_idx.
  - acc at col_idx = IMG_W-1 -> col_idx = 0, go to ROW_WB.
- ROW_WB:
  - pix_ready = 0 (back-pressure); wb_req = 1, held until wb_ack sampled high.
  - On wb_ack with row_idx = IMG_H-3 -> DONE.
  - Otherwise row_idx += 1 and return to RUN.
  - wb_ack outside ROW_WB is ignored.
- DONE:
  - done = 1 for this cycle; irq set; go to IDLE.
- Stalls:
  - pix_valid low holds all counters; no timeout.
- irq:
  - Set in DONE; cleared by irq_clr.
  - irq_clr in the same cycle as DONE -> irq = 1 (set wins).
- abort:
  - High in any non-IDLE state -> next state IDLE, counters cleared.
  - No done, no irq, no dma_start.
  - wb_req drops the cycle after abort.
  - abort in IDLE forces cmd_ready = 0, so a simultaneous cmd_valid is not accepted.
- rst:
  - Mid-frame reset returns to reset values on the next edge, including irq.
- dma_start never asserts outside START. A new command cannot be accepted until IDLE is re-entered.
- Totals:
  - Pixels per frame = IMG_H*IMG_W accepts.
  - Write-backs = IMG_H-2.
- Counter arithmetic:
  - Unsigned, modulo 2^CW / 2^RW.
  - row_idx never exceeds IMG_H-3.

Test Plan:
1. IMG_W=4, IMG_H=4, pix_valid=1, wb_ack one cycle after wb_req, cmd_op=2 -> dma_start pulse the cycle after accept; 8 prime accepts with dp_en=0; 4 dp_en with dp_op=2; wb_req; 4 dp_en; wb_req; done pulse once; irq=1; exactly 16 accepts and 2 write-backs.
2. Same configuration, pix_valid toggling 1/0 each cycle -> col_idx advances only on accepted pixels; same counts as test 1; frame takes about twice as many cycles.
3. Hold wb_ack low for 10 cycles in ROW_WB -> wb_req stays 1; pix_ready stays 0; col_idx and row_idx frozen; resumes on wb_ack.
4. abort asserted during RUN at row_idx=0, col_idx=2 -> IDLE next cycle; busy=0; no done; irq=0; a subsequent command restarts with dma_start and col_idx=0.
5. irq_clr asserted in the same cycle as DONE -> irq=1. irq_clr asserted on the next cycle -> irq=0.
6. cmd_valid held high with abort high in IDLE -> not accepted. Deassert abort -> accepted. rst mid-PRIME -> all outputs return to reset values.

Source files
------------

// File: rtl/coproc_frame_seq.sv
// Frame-level sequencer for the 3x3 filter pass: command accept, DMA kick, two-row
// prime of the row buffers, row streaming with per-row write-back, and completion irq.
module coproc_frame_seq #(
   parameter int unsigned IMG_W = 256,
   parameter int unsigned IMG_H = 256,
   parameter int unsigned CW    = $clog2(IMG_W),
   parameter int unsigned RW    = $clog2(IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic          abort,
   output logic          dma_start,
   input  logic          pix_valid,
   output logic          pix_ready,
   output logic          dp_en,
   output logic [1:0]    dp_op,
   output logic [CW-1:0] col_idx,
   output logic [RW-1:0] row_idx,
   output logic          wb_req,
   input  logic          wb_ack,
   output logic          busy,
   output logic          done,
   output logic          irq,
   input  logic          irq_clr
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StPrime,
      StRun,
      StRowWb,
      StDone
   } state_e;

   localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
   // Valid convolution: the last output row index is IMG_H-3.
   localparam logic [RW-1:0] RowLast = RW'(IMG_H - 3);

   state_e          state_q;
   logic [4:0]      flags_q;  // {busy, pix_ready, dma_start, wb_req, done}
   logic [CW-1:0]   col_q;
   logic [RW-1:0]   row_q;
   logic            prime_row_q;
   logic [1:0]      op_q;
   logic            irq_q;
   logic            acc;

   // Output flags are a pure function of the state being entered, so they are
   // registered together with the state and never glitch.
   function automatic logic [4:0] flags_of(input state_e s);
      unique case (s)
         StIdle:  flags_of = 5'b00000;
         StStart: flags_of = 5'b10100;
         StPrime: flags_of = 5'b11000;
         StRun:   flags_of = 5'b11000;
         StRowWb: flags_of = 5'b10010;
         StDone:  flags_of = 5'b10001;
         default: flags_of = 5'b00000;
      endcase
   endfunction

   assign acc = pix_valid & pix_ready;

   // Frame FSM with counters, latched op and registered output flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         flags_q     <= '0;
         col_q       <= '0;
         row_q       <= '0;
         prime_row_q <= 1'b0;
         op_q        <= '0;
      end else if (state_q != StIdle && abort) begin
         state_q     <= StIdle;
         flags_q     <= flags_of(StIdle);
         col_q       <= '0;
         row_q       <= '0;
         prime_row_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid && !abort) begin
                  op_q        <= cmd_op;
                  col_q       <= '0;
                  row_q       <= '0;
                  prime_row_q <= 1'b0;
                  state_q     <= StStart;
                  flags_q     <= flags_of(StStart);
               end
            end
            StStart: begin
               state_q <= StPrime;
               flags_q <= flags_of(StPrime);
            end
            StPrime: begin
               if (acc) begin
                  if (col_q == ColLast) begin
                     col_q       <= '0;
                     prime_row_q <= ~prime_row_q;
                     // Second wrap: both buffer rows are primed.
                     if (prime_row_q) begin
                        row_q   <= '0;
                        state_q <= StRun;
                        flags_q <= flags_of(StRun);
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            StRun: begin
               if (acc) begin
                  if (col_q == ColLast) begin
                     col_q   <= '0;
                     state_q <= StRowWb;
                     flags_q <= flags_of(StRowWb);
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            StRowWb: begin
               if (wb_ack) begin
                  if (row_q == RowLast) begin
                     state_q <= StDone;
                     flags_q <= flags_of(StDone);
                  end else begin
                     row_q   <= row_q + 1'b1;
                     state_q <= StRun;
                     flags_q <= flags_of(StRun);
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               flags_q <= flags_of(StIdle);
            end
            default: begin
               state_q <= StIdle;
               flags_q <= flags_of(StIdle);
            end
         endcase
      end
   end

   // Sticky interrupt; setting in DONE takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else if (state_q == StDone && !abort) begin
         irq_q <= 1'b1;
      end else if (irq_clr) begin
         irq_q <= 1'b0;
      end
   end

   assign busy      = flags_q[4];
   assign pix_ready = flags_q[3];
   assign dma_start = flags_q[2];
   assign wb_req    = flags_q[1];
   assign done      = flags_q[0];
   assign cmd_ready = (state_q == StIdle) & ~abort;
   assign dp_en     = acc & (state_q == StRun);
   assign dp_op     = op_q;
   assign col_idx   = col_q;
   assign row_idx   = row_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_coproc_frame_seq.sv
// Directed bench for coproc_frame_seq with a 4x4 frame.
module tb_coproc_frame_seq;

   localparam int unsigned IMG_W = 4;
   localparam int unsigned IMG_H = 4;
   localparam int unsigned CW    = 2;
   localparam int unsigned RW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic          abort;
   logic          dma_start;
   logic          pix_valid;
   logic          pix_ready;
   logic          dp_en;
   logic [1:0]    dp_op;
   logic [CW-1:0] col_idx;
   logic [RW-1:0] row_idx;
   logic          wb_req;
   logic          wb_ack;
   logic          busy;
   logic          done;
   logic          irq;
   logic          irq_clr;

   int errors = 0;
   int checks = 0;

   // Event counters sampled mid-cycle
   int acc_cnt = 0;
   int dp_cnt = 0;
   int dp_bad = 0;
   int wb_cnt = 0;
   int dma_cnt = 0;
   int done_cnt = 0;
   logic [1:0] exp_op = 2'd0;

   // Per-frame observations from run_frame
   int hold_viol;
   int wb_viol;
   int wb_len_max;

   coproc_frame_seq #(
      .IMG_W(IMG_W),
      .IMG_H(IMG_H),
      .CW   (CW),
      .RW   (RW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .abort    (abort),
      .dma_start(dma_start),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .dp_en    (dp_en),
      .dp_op    (dp_op),
      .col_idx  (col_idx),
      .row_idx  (row_idx),
      .wb_req   (wb_req),
      .wb_ack   (wb_ack),
      .busy     (busy),
      .done     (done),
      .irq      (irq),
      .irq_clr  (irq_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (pix_valid && pix_ready) acc_cnt++;
         if (dp_en) begin
            dp_cnt++;
            if (dp_op !== exp_op) dp_bad++;
         end
         if (wb_req && wb_ack) wb_cnt++;
         if (dma_start) dma_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [1:0] op);
      cmd_op    = op;
      exp_op    = op;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   // Drives pixels and acks from the START cycle until DONE is visible or the budget expires.
   task automatic run_frame(input bit toggle, input int ack_delay, output int cycles);
      int  n = 0;
      int  wb_wait = 0;
      int  wb_run = 0;
      bit  v = 1'b1;
      bit  acc_now;
      bit  wb_now;
      logic [CW-1:0] cp;
      logic [RW-1:0] rp;
      hold_viol  = 0;
      wb_viol    = 0;
      wb_len_max = 0;
      while (!done && n < 300) begin
         pix_valid = toggle ? v : 1'b1;
         v = ~v;
         if (wb_req) begin
            wb_ack = (wb_wait >= ack_delay);
            wb_wait++;
            wb_run++;
            if (wb_run > wb_len_max) wb_len_max = wb_run;
         end else begin
            wb_ack  = 1'b0;
            wb_wait = 0;
            wb_run  = 0;
         end
         #1;
         acc_now = pix_valid & pix_ready;
         wb_now  = wb_req;
         cp = col_idx;
         rp = row_idx;
         if (wb_now && pix_ready) wb_viol++;
         step();
         n++;
         if (!acc_now && col_idx !== cp) hold_viol++;
         if (wb_now && !wb_ack && (row_idx !== rp || col_idx !== cp || !wb_req)) wb_viol++;
      end
      pix_valid = 1'b0;
      wb_ack    = 1'b0;
      cycles    = n;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; abort = 1'b0;
      pix_valid = 1'b0; wb_ack = 1'b0; irq_clr = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, pix_ready, dma_start, wb_req, done, irq, dp_en} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {busy, pix_ready, dma_start, wb_req, done, irq, dp_en});
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      checks++;
      if ({col_idx, row_idx, dp_op} !== 6'b0) begin
         errors++; $display("FAIL reset_counters: got %b expected 0", {col_idx, row_idx, dp_op});
      end
   endtask

   task automatic test_basic_frame(output int cyc);
      int a0 = acc_cnt, p0 = dp_cnt, b0 = dp_bad, w0 = wb_cnt, m0 = dma_cnt, d0 = done_cnt;
      cmd_op = 2'd2; exp_op = 2'd2; cmd_valid = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready: got %b expected 1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      checks++;
      if (dma_start !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL dma_pulse: got dma=%b busy=%b expected 1 1", dma_start, busy);
      end
      run_frame(1'b0, 1, cyc);
      checks++;
      if (done !== 1'b1 || irq !== 1'b0) begin
         errors++; $display("FAIL basic_done: got done=%b irq=%b expected 1 0", done, irq);
      end
      step();
      checks++;
      if (irq !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL basic_after: got irq=%b busy=%b done=%b expected 1 0 0", irq, busy, done);
      end
      checks++;
      if (acc_cnt - a0 !== 16 || dp_cnt - p0 !== 8) begin
         errors++;
         $display("FAIL basic_pixels: got acc=%0d dp=%0d expected 16 8", acc_cnt - a0, dp_cnt - p0);
      end
      checks++;
      if (wb_cnt - w0 !== 2 || dma_cnt - m0 !== 1 || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL basic_events: got wb=%0d dma=%0d done=%0d expected 2 1 1",
                  wb_cnt - w0, dma_cnt - m0, done_cnt - d0);
      end
      checks++;
      if (dp_bad - b0 !== 0 || dp_op !== 2'd2) begin
         errors++; $display("FAIL basic_dp_op: got bad=%0d op=%0d expected 0 2", dp_bad - b0, dp_op);
      end
      checks++;
      if (row_idx !== 2'd1 || col_idx !== 2'd0) begin
         errors++; $display("FAIL basic_final_idx: got row=%0d col=%0d expected 1 0", row_idx, col_idx);
      end
   endtask

   task automatic test_stall(input int cyc1);
      int cyc2;
      int a0 = acc_cnt, p0 = dp_cnt, w0 = wb_cnt, d0 = done_cnt;
      start_frame(2'd2);
      run_frame(1'b1, 1, cyc2);
      step();
      checks++;
      if (hold_viol !== 0) begin
         errors++; $display("FAIL stall_col_hold: got %0d moves expected 0", hold_viol);
      end
      checks++;
      if (acc_cnt - a0 !== 16 || dp_cnt - p0 !== 8 || wb_cnt - w0 !== 2 || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL stall_counts: got acc=%0d dp=%0d wb=%0d done=%0d expected 16 8 2 1",
                  acc_cnt - a0, dp_cnt - p0, wb_cnt - w0, done_cnt - d0);
      end
      checks++;
      if (cyc2 < cyc1 + 12) begin
         errors++; $display("FAIL stall_duration: got %0d cycles expected at least %0d", cyc2, cyc1 + 12);
      end
   endtask

   task automatic test_wb_hold();
      int cyc;
      int w0 = wb_cnt, d0 = done_cnt, a0 = acc_cnt;
      start_frame(2'd1);
      run_frame(1'b0, 10, cyc);
      step();
      checks++;
      if (wb_len_max !== 11) begin
         errors++; $display("FAIL wb_hold_len: got %0d expected 11", wb_len_max);
      end
      checks++;
      if (wb_viol !== 0) begin
         errors++; $display("FAIL wb_hold_frozen: got %0d violations expected 0", wb_viol);
      end
      checks++;
      if (wb_cnt - w0 !== 2 || done_cnt - d0 !== 1 || acc_cnt - a0 !== 16) begin
         errors++;
         $display("FAIL wb_hold_counts: got wb=%0d done=%0d acc=%0d expected 2 1 16",
                  wb_cnt - w0, done_cnt - d0, acc_cnt - a0);
      end
   endtask

   task automatic test_abort();
      int d0, m0;
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL irq_clear: got %b expected 0", irq);
      end
      d0 = done_cnt;
      m0 = dma_cnt;
      start_frame(2'd3);
      pix_valid = 1'b1;
      repeat (11) step();
      checks++;
      if (col_idx !== 2'd2 || row_idx !== 2'd0 || dp_en !== 1'b1) begin
         errors++;
         $display("FAIL abort_setup: got col=%0d row=%0d dp_en=%b expected 2 0 1", col_idx, row_idx, dp_en);
      end
      abort = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || pix_ready !== 1'b0 || col_idx !== 2'd0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got busy=%b rdy=%b col=%0d cmd_ready=%b expected 0 0 0 0",
                  busy, pix_ready, col_idx, cmd_ready);
      end
      abort = 1'b0;
      pix_valid = 1'b0;
      step();
      step();
      checks++;
      if (done_cnt - d0 !== 0 || irq !== 1'b0 || dma_cnt - m0 !== 1 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_quiet: got done=%0d irq=%b dma=%0d cmd_ready=%b expected 0 0 1 1",
                  done_cnt - d0, irq, dma_cnt - m0, cmd_ready);
      end
      start_frame(2'd3);
      checks++;
      if (dma_start !== 1'b1 || col_idx !== 2'd0) begin
         errors++; $display("FAIL abort_restart: got dma=%b col=%0d expected 1 0", dma_start, col_idx);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_irq_clr_race();
      int cyc;
      start_frame(2'd0);
      run_frame(1'b0, 1, cyc);
      irq_clr = 1'b1;
      step();
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL irq_set_wins: got %b expected 1", irq);
      end
      step();
      irq_clr = 1'b0;
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL irq_clr_next: got %b expected 0", irq);
      end
   endtask

   task automatic test_abort_idle_and_rst();
      int cyc;
      start_frame(2'd2);
      run_frame(1'b0, 1, cyc);
      step();
      abort = 1'b1; cmd_op = 2'd1; exp_op = 2'd1; cmd_valid = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++; $display("FAIL idle_abort_ready: got %b expected 0", cmd_ready);
      end
      step();
      checks++;
      if (busy !== 1'b0 || dma_start !== 1'b0) begin
         errors++; $display("FAIL idle_abort_block: got busy=%b dma=%b expected 0 0", busy, dma_start);
      end
      abort = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL idle_release_ready: got %b expected 1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      checks++;
      if (dma_start !== 1'b1 || dp_op !== 2'd1) begin
         errors++; $display("FAIL idle_release_accept: got dma=%b op=%0d expected 1 1", dma_start, dp_op);
      end
      pix_valid = 1'b1;
      repeat (3) step();
      checks++;
      if (col_idx !== 2'd2 || pix_ready !== 1'b1 || irq !== 1'b1) begin
         errors++;
         $display("FAIL prime_mid: got col=%0d rdy=%b irq=%b expected 2 1 1", col_idx, pix_ready, irq);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({busy, pix_ready, dma_start, wb_req, done, irq, dp_en} !== 7'b0) begin
         errors++;
         $display("FAIL rst_mid_flags: got %b expected 0000000",
                  {busy, pix_ready, dma_start, wb_req, done, irq, dp_en});
      end
      checks++;
      if ({col_idx, row_idx, dp_op} !== 6'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_state: got idx=%b cmd_ready=%b expected 0 1",
                  {col_idx, row_idx, dp_op}, cmd_ready);
      end
      rst = 1'b0;
      pix_valid = 1'b0;
      step();
   endtask

   initial begin
      int cyc1;
      test_reset();
      test_basic_frame(cyc1);
      test_stall(cyc1);
      test_wb_hold();
      test_abort();
      test_irq_clr_race();
      test_abort_idle_and_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
